// File: rtl/pattern_scan_pkg.sv
// Shared state encoding and default widths for the serial pattern scan controller.
package pattern_scan_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int LEN_W_DEF = 4;
  localparam int WIN_W_DEF = 16;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pattern_shift_match.sv
// Sample history shift register with fill tracking and a length-masked pattern compare.
// match_next reflects the history as it will be after the current shift.
module pattern_shift_match
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift,
  input  logic             d_in,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  output logic             match_next
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] FILL_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [PAT_W-1:0] history_r;
  logic [LEN_W-1:0] fill_r;
  logic [PAT_W-1:0] history_next_s;
  logic [LEN_W-1:0] fill_next_s;
  logic [PAT_W-1:0] mask_s;

  // next history and fill; fill stops at PAT_W so it never wraps
  always_comb begin
    history_next_s = history_r;
    fill_next_s    = fill_r;
    if (shift) begin
      history_next_s = {history_r[PAT_W-2:0], d_in};
      if (fill_r < FILL_MAX) begin
        fill_next_s = fill_r + FILL_ONE;
      end else begin
        fill_next_s = fill_r;
      end
    end else begin
      history_next_s = history_r;
      fill_next_s    = fill_r;
    end
  end

  // mask of the low len bits, built bitwise to avoid shift overflow at len == PAT_W
  always_comb begin
    mask_s = {PAT_W{1'b0}};
    for (int i = 0; i < PAT_W; i++) begin
      mask_s[i] = (i < int'(len));
    end
  end

  assign match_next = shift && (fill_next_s >= len) &&
                      (((history_next_s ^ pattern) & mask_s) == {PAT_W{1'b0}});

  // history and fill registers
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      history_r <= {PAT_W{1'b0}};
      fill_r    <= {LEN_W{1'b0}};
    end else if (shift) begin
      history_r <= history_next_s;
      fill_r    <= fill_next_s;
    end else begin
      history_r <= history_r;
      fill_r    <= fill_r;
    end
  end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Run controller: latches cfg on start, scans cfg_window valid samples,
// counts overlapping matches with saturation and pulses done at window end.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int WIN_W = WIN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] cfg_pattern,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [WIN_W-1:0] cfg_window,
  input  logic             d_in,
  input  logic             valid_in,
  output logic             busy,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat,
  output logic             done,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [WIN_W-1:0] WIN_ONE = {{(WIN_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_r;
  state_t           state_next_s;
  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic [WIN_W-1:0] win_r;
  logic [WIN_W-1:0] win_cnt_r;
  logic             busy_r;
  logic             match_pulse_r;
  logic [CNT_W-1:0] match_count_r;
  logic             count_sat_r;
  logic             done_r;
  logic             cfg_err_r;

  logic cfg_ok_s;
  logic accept_s;
  logic start_err_s;
  logic sample_s;
  logic last_s;
  logic match_next_s;

  assign cfg_ok_s    = (cfg_len != {LEN_W{1'b0}}) && (cfg_len <= LEN_MAX) &&
                       (cfg_window != {WIN_W{1'b0}});
  assign accept_s    = (state_r == S_IDLE) && start && cfg_ok_s;
  assign start_err_s = (state_r == S_IDLE) && start && !cfg_ok_s;
  // abort drops any sample presented in the same cycle
  assign sample_s    = (state_r == S_RUN) && valid_in && !abort;
  assign last_s      = sample_s && (win_cnt_r == (win_r - WIN_ONE));

  pattern_shift_match #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shift_match (
    .clk        (clk),
    .rst        (rst),
    .clr        (accept_s),
    .shift      (sample_s),
    .d_in       (d_in),
    .len        (len_r),
    .pattern    (pat_r),
    .match_next (match_next_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_next_s = S_RUN;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next_s = S_IDLE;
        end else if (last_s) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_RUN;
        end
      end
      S_DONE:  state_next_s = S_IDLE;
      default: state_next_s = S_IDLE;
    endcase
  end

  // configuration latches and window sample counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r     <= {PAT_W{1'b0}};
      len_r     <= {LEN_W{1'b0}};
      win_r     <= {WIN_W{1'b0}};
      win_cnt_r <= {WIN_W{1'b0}};
    end else if (accept_s) begin
      pat_r     <= cfg_pattern;
      len_r     <= cfg_len;
      win_r     <= cfg_window;
      win_cnt_r <= {WIN_W{1'b0}};
    end else if (sample_s) begin
      win_cnt_r <= win_cnt_r + WIN_ONE;
    end else begin
      win_cnt_r <= win_cnt_r;
    end
  end

  // registered status pulses and saturating match counter
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r        <= 1'b0;
      match_pulse_r <= 1'b0;
      done_r        <= 1'b0;
      cfg_err_r     <= 1'b0;
      match_count_r <= {CNT_W{1'b0}};
      count_sat_r   <= 1'b0;
    end else begin
      busy_r        <= (state_next_s == S_RUN);
      match_pulse_r <= sample_s && match_next_s;
      done_r        <= last_s;
      cfg_err_r     <= start_err_s;
      if (accept_s) begin
        match_count_r <= {CNT_W{1'b0}};
        count_sat_r   <= 1'b0;
      end else if (sample_s && match_next_s) begin
        if (&match_count_r) begin
          count_sat_r <= 1'b1;
        end else begin
          match_count_r <= match_count_r + CNT_ONE;
        end
      end else begin
        match_count_r <= match_count_r;
        count_sat_r   <= count_sat_r;
      end
    end
  end

  assign busy        = busy_r;
  assign match_pulse = match_pulse_r;
  assign match_count = match_count_r;
  assign count_sat   = count_sat_r;
  assign done        = done_r;
  assign cfg_err     = cfg_err_r;

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Self-checking bench for pattern_scan_ctrl: table-driven runs with a match scoreboard,
// plus directed sequences for cfg errors, abort, start-while-busy and mid-run reset.
module tb_pattern_scan_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int WIN_W = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0] cfg_len = '0;
  logic [WIN_W-1:0] cfg_window = '0;
  logic             d_in = 1'b0;
  logic             valid_in = 1'b0;
  logic             busy;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             count_sat;
  logic             done;
  logic             cfg_err;

  int checks = 0;
  int errors = 0;
  bit sb_q[$];

  typedef struct {
    logic [LEN_W-1:0] len;
    logic [PAT_W-1:0] pat;
    logic [WIN_W-1:0] win;
    logic [31:0]      bits;   // bit i = i-th received sample
    int               gap;    // idle cycles before each valid sample
    logic [CNT_W-1:0] exp_cnt;
    logic             exp_sat;
  } vec_t;

  vec_t vecs[5];

  pattern_scan_ctrl #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .WIN_W (WIN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_window  (cfg_window),
    .d_in        (d_in),
    .valid_in    (valid_in),
    .busy        (busy),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .count_sat   (count_sat),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned hist;
    int          fill;
    int unsigned mask;
    bit          m;
    hist = 0;
    fill = 0;
    mask = (32'd1 << v.len) - 32'd1;
    cfg_len = v.len;
    cfg_pattern = v.pat;
    cfg_window = v.win;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("run_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < int'(v.win); i++) begin
      for (int g = 0; g < v.gap; g++) begin
        valid_in = 1'b0;
        d_in = ~v.bits[i];
        tick();
        chk("gap_no_pulse", {31'd0, match_pulse}, 32'd0);
      end
      d_in = v.bits[i];
      valid_in = 1'b1;
      hist = (hist << 1) | {31'd0, v.bits[i]};
      if (fill < PAT_W) fill++;
      m = (fill >= int'(v.len)) && ((hist & mask) == ({24'd0, v.pat} & mask));
      sb_q.push_back(m);
      tick();
      valid_in = 1'b0;
      chk("match_pulse", {31'd0, match_pulse}, {31'd0, sb_q.pop_front()});
      chk("done_timing", {31'd0, done}, (i == int'(v.win) - 1) ? 32'd1 : 32'd0);
    end
    tick();
    chk("done_once", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("match_count", {28'd0, match_count}, {28'd0, v.exp_cnt});
    chk("count_sat", {31'd0, count_sat}, {31'd0, v.exp_sat});
  endtask

  initial begin
    logic [LEN_W-1:0] bad_len[3];
    logic [WIN_W-1:0] bad_win[3];
    bit               ab_exp[4];

    vecs[0] = '{len: 4'd3, pat: 8'h05, win: 16'd8,  bits: 32'h0000_00B5, gap: 0, exp_cnt: 4'd3,  exp_sat: 1'b0};
    vecs[1] = '{len: 4'd2, pat: 8'h03, win: 16'd6,  bits: 32'hFFFF_FFFF, gap: 1, exp_cnt: 4'd5,  exp_sat: 1'b0};
    vecs[2] = '{len: 4'd1, pat: 8'h01, win: 16'd20, bits: 32'hFFFF_FFFF, gap: 0, exp_cnt: 4'd15, exp_sat: 1'b1};
    vecs[3] = '{len: 4'd8, pat: 8'hA5, win: 16'd12, bits: 32'h0000_05A5, gap: 0, exp_cnt: 4'd1,  exp_sat: 1'b0};
    vecs[4] = '{len: 4'd4, pat: 8'h00, win: 16'd6,  bits: 32'h0000_0000, gap: 2, exp_cnt: 4'd3,  exp_sat: 1'b0};

    // reset state
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_pulse", {31'd0, match_pulse}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cfg_err", {31'd0, cfg_err}, 32'd0);
    chk("rst_sat", {31'd0, count_sat}, 32'd0);
    chk("rst_count", {28'd0, match_count}, 32'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 5; k++) begin
      run_vec(vecs[k]);
      tick();
    end

    // illegal configurations: len 0, len > PAT_W, window 0
    bad_len = '{4'd0, 4'd9, 4'd3};
    bad_win = '{16'd8, 16'd8, 16'd0};
    for (int k = 0; k < 3; k++) begin
      cfg_len = bad_len[k];
      cfg_window = bad_win[k];
      cfg_pattern = 8'h05;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("cfg_err_pulse", {31'd0, cfg_err}, 32'd1);
      chk("cfg_err_busy", {31'd0, busy}, 32'd0);
      tick();
      chk("cfg_err_clear", {31'd0, cfg_err}, 32'd0);
      chk("cfg_err_count", {28'd0, match_count}, {28'd0, vecs[4].exp_cnt});
    end

    // abort after 4 samples with 2 matches; the same-cycle sample is dropped
    cfg_len = 4'd2;
    cfg_pattern = 8'h03;
    cfg_window = 16'd10;
    start = 1'b1;
    tick();
    start = 1'b0;
    ab_exp = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int k = 0; k < 4; k++) begin
      d_in = (k != 0);
      valid_in = 1'b1;
      sb_q.push_back(ab_exp[k]);
      tick();
      valid_in = 1'b0;
      chk("abort_run_pulse", {31'd0, match_pulse}, {31'd0, sb_q.pop_front()});
    end
    abort = 1'b1;
    valid_in = 1'b1;
    d_in = 1'b1;
    tick();
    abort = 1'b0;
    valid_in = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_drop", {31'd0, match_pulse}, 32'd0);
    chk("abort_count", {28'd0, match_count}, 32'd2);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_no_done", {31'd0, done}, 32'd0);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle_ignored", {28'd0, match_count}, 32'd2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_clear", {28'd0, match_count}, 32'd0);
    chk("restart_busy", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();

    // start held high while busy, cfg changed mid-run: run length stays 3
    cfg_len = 4'd1;
    cfg_pattern = 8'h01;
    cfg_window = 16'd3;
    start = 1'b1;
    tick();
    cfg_window = 16'd1;
    cfg_len = 4'd0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) start = 1'b0;
      d_in = 1'b1;
      valid_in = 1'b1;
      tick();
      valid_in = 1'b0;
      chk("busy_start_done", {31'd0, done}, (k == 2) ? 32'd1 : 32'd0);
      chk("busy_start_no_err", {31'd0, cfg_err}, 32'd0);
    end
    chk("busy_start_count", {28'd0, match_count}, 32'd3);
    tick();
    chk("busy_start_idle", {31'd0, busy}, 32'd0);

    // synchronous reset mid-run
    cfg_len = 4'd1;
    cfg_pattern = 8'h01;
    cfg_window = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      d_in = 1'b1;
      valid_in = 1'b1;
      tick();
    end
    valid_in = 1'b0;
    chk("pre_rst_count", {28'd0, match_count}, 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_count", {28'd0, match_count}, 32'd0);
    chk("midrst_pulse", {31'd0, match_pulse}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      d_in = 1'b1;
      valid_in = 1'b1;
      tick();
      chk("midrst_no_done", {31'd0, done}, 32'd0);
      chk("midrst_idle", {31'd0, busy}, 32'd0);
    end
    valid_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
